stack_arbiter: RTL and testbench

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_arbiter.sv | 150 +++++++++++++++
 tb/tb_stack_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : stack_arbiter
// Description : Round-robin arbiter that serialises two requesters onto a
//               single external stack (clear / push / pop), returning popped
//               data and an error flag. Optional macro STACK_ARB_PRECHECK_EN
//               suppresses push-on-full and pop-on-empty before issue.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_arbiter #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req,
    input  logic [3:0]      op,
    input  logic [2*DW-1:0] wdata,
    output logic [1:0]      gnt,
    output logic [1:0]      done,
    output logic [DW-1:0]   rdata,
    output logic            err,
    output logic            busy,
    output logic [1:0]      stk_cmd,
    output logic [DW-1:0]   stk_din,
    input  logic [DW-1:0]   stk_dout,
    input  logic            stk_full,
    input  logic            stk_empty,
    input  logic            stk_error
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    localparam logic [1:0] c_OP_NOP  = 2'b00;
    localparam logic [1:0] c_OP_CLR  = 2'b01;
    localparam logic [1:0] c_OP_PUSH = 2'b10;
    localparam logic [1:0] c_OP_POP  = 2'b11;

    state_t      r_state;
    logic        r_init_sent;
    logic        r_last_b;
    logic [1:0]  r_op;
    logic        r_block;

    logic          w_win_b;
    logic [1:0]    w_sel_op;
    logic [DW-1:0] w_sel_wdata;
    logic          w_block;
    logic          w_resp_err;

    // Round-robin: on a tie the requester not served last wins.
    always_comb begin
        w_win_b = 1'b0;
        case (req)
            2'b01:   w_win_b = 1'b0;
            2'b10:   w_win_b = 1'b1;
            2'b11:   w_win_b = ~r_last_b;
            default: w_win_b = 1'b0;
        endcase
    end

    assign w_sel_op    = w_win_b ? op[3:2] : op[1:0];
    assign w_sel_wdata = w_win_b ? wdata[2*DW-1:DW] : wdata[DW-1:0];

`ifdef STACK_ARB_PRECHECK_EN
    // Flags are stable in IDLE, so the decision is taken as ISSUE is entered.
    assign w_block = ((w_sel_op == c_OP_PUSH) && stk_full) ||
                     ((w_sel_op == c_OP_POP)  && stk_empty);
`else
    logic w_unused_flags;
    assign w_unused_flags = stk_full | stk_empty;
    assign w_block        = 1'b0;
`endif

    // A no-op never touches the stack, so a stale stack error must not leak.
    assign w_resp_err = r_block | ((r_op != c_OP_NOP) & stk_error);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_init_sent <= 1'b0;
            r_last_b    <= 1'b1;
            r_op        <= c_OP_NOP;
            r_block     <= 1'b0;
            gnt         <= 2'b00;
            done        <= 2'b00;
            rdata       <= '0;
            err         <= 1'b0;
            busy        <= 1'b1;
            stk_cmd     <= c_OP_NOP;
            stk_din     <= '0;
        end else begin
            done <= 2'b00;
            case (r_state)
                ST_INIT: begin
                    if (!r_init_sent) begin
                        stk_cmd     <= c_OP_CLR;
                        r_init_sent <= 1'b1;
                    end else begin
                        stk_cmd <= c_OP_NOP;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (|req) begin
                        r_last_b <= w_win_b;
                        r_op     <= w_sel_op;
                        r_block  <= w_block;
                        gnt      <= w_win_b ? 2'b10 : 2'b01;
                        stk_cmd  <= w_block ? c_OP_NOP : w_sel_op;
                        stk_din  <= w_sel_wdata;
                        busy     <= 1'b1;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    stk_cmd <= c_OP_NOP;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    err <= w_resp_err;
                    if ((r_op == c_OP_POP) && !w_resp_err) begin
                        rdata <= stk_dout;
                    end
                    done    <= gnt;
                    gnt     <= 2'b00;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    stk_cmd <= c_OP_NOP;
                    gnt     <= 2'b00;
                    busy    <= 1'b1;
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_arbiter
// Description : Scoreboard bench for stack_arbiter with a depth-8 stack model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_arbiter;

    localparam int DW = 8;
    localparam logic [1:0] c_NOP  = 2'b00;
    localparam logic [1:0] c_CLR  = 2'b01;
    localparam logic [1:0] c_PUSH = 2'b10;
    localparam logic [1:0] c_POP  = 2'b11;

    logic            clk;
    logic            rst;
    logic [1:0]      req;
    logic [3:0]      op;
    logic [2*DW-1:0] wdata;
    logic [1:0]      gnt;
    logic [1:0]      done;
    logic [DW-1:0]   rdata;
    logic            err;
    logic            busy;
    logic [1:0]      stk_cmd;
    logic [DW-1:0]   stk_din;
    logic [DW-1:0]   stk_dout;
    logic            stk_full;
    logic            stk_empty;
    logic            stk_error;

    stack_arbiter #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op        (op),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .busy      (busy),
        .stk_cmd   (stk_cmd),
        .stk_din   (stk_din),
        .stk_dout  (stk_dout),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_error (stk_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal depth-8 stack; not reset by rst, only by a CLR command.
    logic [DW-1:0] mem [8];
    int            sp     = 0;
    logic [DW-1:0] s_dout = '0;
    logic          s_err  = 1'b0;
    always @(posedge clk) begin
        case (stk_cmd)
            c_CLR: begin
                sp    <= 0;
                s_err <= 1'b0;
            end
            c_PUSH: begin
                if (sp == 8) s_err <= 1'b1;
                else begin
                    mem[sp] <= stk_din;
                    sp      <= sp + 1;
                    s_err   <= 1'b0;
                end
            end
            c_POP: begin
                if (sp == 0) s_err <= 1'b1;
                else begin
                    s_dout <= mem[sp-1];
                    sp     <= sp - 1;
                    s_err  <= 1'b0;
                end
            end
            default: ;
        endcase
    end
    assign stk_dout  = s_dout;
    assign stk_full  = (sp == 8);
    assign stk_empty = (sp == 0);
    assign stk_error = s_err;

    typedef struct packed {
        logic [1:0]    who;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (done != 2'b00)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {30'd0, done}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("done_who", {30'd0, done}, {30'd0, e.who});
                check("err", {31'd0, err}, {31'd0, e.err});
                check("rdata", {24'd0, rdata}, {24'd0, e.rdata});
            end
        end
    end

    task automatic expect_resp(input int who, input logic e_err, input logic [DW-1:0] e_rd);
        exp_t e;
        e.who   = (who != 0) ? 2'b10 : 2'b01;
        e.err   = e_err;
        e.rdata = e_rd;
        sb_q.push_back(e);
    endtask

    // One request by one requester; returns cycles to done and the first stack command.
    task automatic do_op(input int who, input logic [1:0] o, input logic [DW-1:0] d,
                         input logic e_err, input logic [DW-1:0] e_rd,
                         output int lat, output logic [1:0] first_cmd);
        int t0;
        bit got;
        expect_resp(who, e_err, e_rd);
        req[who]            = 1'b1;
        op[who*2 +: 2]      = o;
        wdata[who*DW +: DW] = d;
        t0        = cyc;
        got       = 1'b0;
        first_cmd = 2'b00;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (i == 0) first_cmd = stk_cmd;
            if (done[who]) got = 1'b1;
        end
        lat                 = cyc - t0;
        req[who]            = 1'b0;
        op[who*2 +: 2]      = c_NOP;
        wdata[who*DW +: DW] = '0;
        if (!got) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int         lat;
        logic [1:0] fc;
        logic [1:0] grants [4];
        int         dcyc [4];
        int         ng;
        int         nd;
        logic [1:0] prev_gnt;

        rst   = 1'b1;
        req   = 2'b00;
        op    = 4'h0;
        wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_done", {30'd0, done}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_stk_cmd", {30'd0, stk_cmd}, 32'd0);
        check("rst_stk_din", {24'd0, stk_din}, 32'd0);
        rst = 1'b0;

        @(posedge clk); #1;
        check("init_clr", {30'd0, stk_cmd}, {30'd0, c_CLR});
        check("init_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check("init_exit_cmd", {30'd0, stk_cmd}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Pop on an empty stack straight after INIT.
        do_op(0, c_POP, 8'h00, 1'b1, 8'h00, lat, fc);
        // A pushes 0x5A, B pops it back.
        do_op(0, c_PUSH, 8'h5A, 1'b0, 8'h00, lat, fc);
        check("push_latency", lat, 32'd4);
        check("push_cmd", {30'd0, fc}, {30'd0, c_PUSH});
        do_op(1, c_POP, 8'h00, 1'b0, 8'h5A, lat, fc);
        check("pop_cmd", {30'd0, fc}, {30'd0, c_POP});

        // Both requesting continuously: last served was B, so A first.
        expect_resp(0, 1'b0, 8'h5A);
        expect_resp(1, 1'b0, 8'h5A);
        expect_resp(0, 1'b0, 8'h5A);
        expect_resp(1, 1'b0, 8'h5A);
        req      = 2'b11;
        op       = {c_PUSH, c_PUSH};
        wdata    = {8'h22, 8'h11};
        ng       = 0;
        nd       = 0;
        prev_gnt = 2'b00;
        for (int i = 0; i < 40 && nd < 4; i++) begin
            @(posedge clk); #1;
            if ((gnt != 2'b00) && (prev_gnt == 2'b00) && (ng < 4)) begin
                grants[ng] = gnt;
                ng++;
            end
            prev_gnt = gnt;
            if (done != 2'b00) begin
                dcyc[nd] = cyc;
                nd++;
            end
        end
        req   = 2'b00;
        op    = 4'h0;
        wdata = '0;
        check("rr_grants_seen", ng, 32'd4);
        check("rr_dones_seen", nd, 32'd4);
        if (ng == 4) begin
            check("rr_gnt0", {30'd0, grants[0]}, 32'd1);
            check("rr_gnt1", {30'd0, grants[1]}, 32'd2);
            check("rr_gnt2", {30'd0, grants[2]}, 32'd1);
            check("rr_gnt3", {30'd0, grants[3]}, 32'd2);
        end
        if (nd == 4) begin
            for (int k = 1; k < 4; k++) check("rr_done_gap", dcyc[k] - dcyc[k-1], 32'd4);
        end

        // Clear, fill to depth, drain in LIFO order, then one extra pop.
        do_op(0, c_CLR, 8'h00, 1'b0, 8'h5A, lat, fc);
        for (int i = 1; i <= 8; i++) do_op(0, c_PUSH, i[7:0], 1'b0, 8'h5A, lat, fc);
        for (int i = 8; i >= 1; i--) do_op(1, c_POP, 8'h00, 1'b0, i[7:0], lat, fc);
        do_op(1, c_POP, 8'h00, 1'b1, 8'h01, lat, fc);
`ifdef STACK_ARB_PRECHECK_EN
        check("underflow_cmd", {30'd0, fc}, {30'd0, c_NOP});
`else
        check("underflow_cmd", {30'd0, fc}, {30'd0, c_POP});
`endif
        do_op(0, c_NOP, 8'h00, 1'b0, 8'h01, lat, fc);

        // Reset during WAIT: push 0x77 reaches the stack, then is abandoned.
        req[0]     = 1'b1;
        op[1:0]    = c_PUSH;
        wdata[7:0] = 8'h77;
        @(posedge clk); #1;
        check("abort_gnt", {30'd0, gnt}, 32'd1);
        @(posedge clk); #1;
        check("abort_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_gnt_clr", {30'd0, gnt}, 32'd0);
        req   = 2'b00;
        op    = 4'h0;
        wdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", {30'd0, done}, 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("reinit_clr", {30'd0, stk_cmd}, {30'd0, c_CLR});
        @(posedge clk); #1;
        check("reinit_idle", {31'd0, busy}, 32'd0);
        do_op(1, c_POP, 8'h00, 1'b1, 8'h00, lat, fc);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
